// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, in-order imem requests, instruction buffer, redirect flush
//
// Purpose:
//   Holds the PC and issues word-aligned requests to instruction memory.
//   Returned words are paired with their PC and buffered in a DEPTH-entry FIFO,
//   which feeds decode through a valid/ready handshake. A redirect from execute
//   reloads the PC, clears the buffer and discards responses still in flight.
//
// Ports:
//   clk_i, rstn_i           clock, synchronous active-low reset
//   imem_req_valid_o/addr_o request to instruction memory (word-aligned)
//   imem_req_ready_i        memory accepts the request
//   imem_rsp_valid_i/data_i in-order response from instruction memory
//   redirect_i/redirect_pc_i taken branch/jump target from execute
//   instr_o/instr_valid_o   {pc, word} presented to decode
//   instr_ready_i           decode accepts instr_o

package fetch_pkg;
  typedef logic [31:0] bus32_t;

  typedef struct packed {
    bus32_t pc;
    bus32_t word;
  } instr_data_t;
endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter bus32_t      RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        imem_req_valid_o,
  output bus32_t      imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  bus32_t      imem_rsp_data_i,
  input  logic        redirect_i,
  input  bus32_t      redirect_pc_i,
  output instr_data_t instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_W = CW1'(DEPTH);

  // Architectural state
  bus32_t        pc_r;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;

  // PC queue: PCs of requests awaiting their response
  bus32_t        pcq_mem [DEPTH];
  logic [AW-1:0] pcq_rd;
  logic [AW-1:0] pcq_wr;

  // Instruction buffer
  instr_data_t   fifo_mem [DEPTH];
  logic [AW-1:0] fifo_rd;
  logic [AW-1:0] fifo_wr;
  logic [CW-1:0] fifo_cnt;

  logic          req_fire;
  logic          rsp_accept;
  logic          fifo_push;
  logic          fifo_pop;
  logic [CW:0]   credit_used;
  bus32_t        redirect_target;

  // Outputs to decode depend on buffer state only.
  assign instr_valid_o = (fifo_cnt != '0);
  assign instr_o       = instr_valid_o ? fifo_mem[fifo_rd] : '0;

  assign fifo_pop   = instr_valid_o && instr_ready_i && !redirect_i;
  assign rsp_accept = imem_rsp_valid_i && (inflight != '0);
  assign fifo_push  = rsp_accept && (drop_cnt == '0) && !redirect_i;

  // Credits: every in-flight request owns a buffer slot. The entry decode takes
  // this cycle frees its slot immediately, which is what lets a DEPTH=2 buffer
  // sustain one instruction per cycle behind a 1-cycle memory.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_cnt} - CW1'(fifo_pop);

  assign imem_req_valid_o = rstn_i && !redirect_i && (credit_used < DEPTH_W);
  assign imem_req_addr_o  = {pc_r[31:2], 2'b00};
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign redirect_target  = redirect_pc_i & ~32'h0000_0003;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pc_r     <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      pcq_rd   <= '0;
      pcq_wr   <= '0;
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      fifo_cnt <= '0;
    end else begin
      // The PC queue tracks every outstanding request, including those being
      // dropped, so it keeps running across redirects.
      if (req_fire) begin
        pcq_wr <= pcq_wr + AW'(1);
      end
      if (rsp_accept) begin
        pcq_rd <= pcq_rd + AW'(1);
      end
      inflight <= inflight + CW'(req_fire) - CW'(rsp_accept);

      if (redirect_i) begin
        pc_r     <= redirect_target;
        fifo_rd  <= '0;
        fifo_wr  <= '0;
        fifo_cnt <= '0;
        // Everything still outstanding after this cycle belongs to the old
        // path; any earlier drop count is a subset of inflight, so this also
        // covers back-to-back redirects.
        drop_cnt <= inflight - CW'(rsp_accept);
      end else begin
        if (req_fire) begin
          pc_r <= pc_r + 32'd4;
        end
        if (rsp_accept && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (fifo_push) begin
          fifo_wr <= fifo_wr + AW'(1);
        end
        if (fifo_pop) begin
          fifo_rd <= fifo_rd + AW'(1);
        end
        fifo_cnt <= fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
      end
    end
  end

  // Storage arrays carry no reset; validity comes from the pointers/counts.
  always_ff @(posedge clk_i) begin
    if (req_fire) begin
      pcq_mem[pcq_wr] <= pc_r;
    end
    if (fifo_push) begin
      fifo_mem[fifo_wr] <= '{pc: pcq_mem[pcq_rd], word: imem_rsp_data_i};
    end
  end

  // A response with nothing outstanding is a memory protocol error; it is ignored.
  a_rsp_has_request : assert property (
    @(posedge clk_i) disable iff (!rstn_i) imem_rsp_valid_i |-> (inflight != '0));

  a_fifo_no_overflow : assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    (fifo_push && !fifo_pop) |-> (fifo_cnt < CW'(DEPTH)));

  a_no_req_overrun : assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    req_fire |-> (inflight < CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam bus32_t RESET_PC = 32'h0000_0000;
  localparam int     DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        imem_req_valid_o;
  bus32_t      imem_req_addr_o;
  logic        imem_req_ready_i = 1'b0;
  logic        imem_rsp_valid_i = 1'b0;
  bus32_t      imem_rsp_data_i = '0;
  logic        redirect_i = 1'b0;
  bus32_t      redirect_pc_i = '0;
  instr_data_t instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .instr_o          (instr_o),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bus32_t addr;
    int     due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  instr_data_t exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  bit          mem_accept = 1'b0;
  bit          toggle_mode = 1'b0;
  bit          tog = 1'b0;
  bus32_t      exp_pc = RESET_PC;
  int          hs_count = 0;

  function automatic bus32_t mem_word(bus32_t a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Instruction memory: in-order responses mem_lat cycles after the handshake.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    imem_req_ready_i = mem_accept && (!toggle_mode || tog);
    tog = !tog;
  end

  // Scoreboard: expectation pushed at each request handshake, popped when decode takes an instruction.
  always @(negedge clk) begin
    if (!rstn_i) begin
      exp_q.delete();
      mem_q.delete();
      exp_pc = RESET_PC;
    end else if (redirect_i) begin
      checks++;
      if (imem_req_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL redirect_no_req: req_valid=%b expected 0", imem_req_valid_o);
      end
      exp_q.delete();
      exp_pc = redirect_pc_i & ~32'h3;
    end else begin
      if (instr_valid_o && instr_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc=%h word=%h, expected no instruction", instr_o.pc, instr_o.word);
        end else begin
          instr_data_t e;
          e = exp_q.pop_front();
          if (instr_o !== e) begin
            errors++;
            $display("FAIL sb_instr: got pc=%h word=%h, expected pc=%h word=%h",
                     instr_o.pc, instr_o.word, e.pc, e.word);
          end
        end
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        checks++;
        if (imem_req_addr_o !== exp_pc) begin
          errors++;
          $display("FAIL req_addr: got %h expected %h", imem_req_addr_o, exp_pc);
        end
        mem_q.push_back('{addr: imem_req_addr_o, due: cyc + mem_lat});
        exp_q.push_back('{pc: exp_pc, word: mem_word(exp_pc)});
        hs_count++;
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rstn_i = 1'b0;
    redirect_i = 1'b0;
    next_cycle();
    next_cycle();
    rstn_i = 1'b1;
  endtask

  task automatic drain(string name);
    mem_accept = 1'b0;
    instr_ready_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d instructions never delivered, expected 0", name, exp_q.size());
    end
    next_cycle();
  endtask

  task automatic test_reset();
    mem_accept = 1'b1; mem_lat = 1; toggle_mode = 1'b0; instr_ready_i = 1'b1;
    next_cycle();
    rstn_i = 1'b0;
    next_cycle();
    @(negedge clk);
    checks += 3;
    if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid_o); end
    if (instr_o !== '0) begin errors++; $display("FAIL reset_instr_o: got %h expected 0", instr_o); end
    if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid_o); end
    next_cycle();
    rstn_i = 1'b1;
    @(negedge clk);
    checks += 2;
    if (imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL reset_first_req_valid: got %b expected 1", imem_req_valid_o); end
    if (imem_req_addr_o !== RESET_PC) begin errors++; $display("FAIL reset_first_addr: got %h expected %h", imem_req_addr_o, RESET_PC); end
    drain("reset");
  endtask

  task automatic test_stream();
    mem_accept = 1'b1; mem_lat = 1; toggle_mode = 1'b0; instr_ready_i = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (instr_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL stream_continuous: cycle %0d instr_valid=%b expected 1", i, instr_valid_o);
        end
      end
    end
    drain("stream");
  endtask

  task automatic test_stall();
    mem_accept = 1'b1; mem_lat = 1; toggle_mode = 1'b0; instr_ready_i = 1'b0;
    do_reset();
    hs_count = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (instr_valid_o !== 1'b1 || instr_o.pc !== 32'h0 || instr_o.word !== mem_word(32'h0)) begin
          errors++;
          $display("FAIL stall_hold: valid=%b pc=%h word=%h expected valid=1 pc=0 word=%h",
                   instr_valid_o, instr_o.pc, instr_o.word, mem_word(32'h0));
        end
      end
    end
    next_cycle();
    checks++;
    if (hs_count != DEPTH) begin
      errors++;
      $display("FAIL stall_req_count: got %0d requests expected %0d", hs_count, DEPTH);
    end
    instr_ready_i = 1'b1;
    repeat (8) @(negedge clk);
    drain("stall");
  endtask

  task automatic test_redirect();
    bit seen;
    mem_accept = 1'b1; mem_lat = 3; toggle_mode = 1'b0; instr_ready_i = 1'b1;
    do_reset();
    next_cycle();
    next_cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    @(negedge clk);
    checks++;
    if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL redirect_early_valid: got %b expected 0", instr_valid_o); end
    next_cycle();
    redirect_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid_o) begin
        seen = 1'b1;
        checks++;
        if (instr_o.pc !== 32'h0000_0100) begin
          errors++;
          $display("FAIL redirect_first_pc: got %h expected 00000100", instr_o.pc);
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL redirect_timeout: instr_valid=0 expected 1 within 20 cycles"); end
    repeat (10) @(negedge clk);
    drain("redirect");
  endtask

  task automatic test_redirect_rsp();
    mem_accept = 1'b1; mem_lat = 1; toggle_mode = 1'b0; instr_ready_i = 1'b1;
    do_reset();
    repeat (6) next_cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    next_cycle();
    redirect_i = 1'b0;
    @(negedge clk);
    checks += 3;
    if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL redir_rsp_fifo_empty: instr_valid=%b expected 0", instr_valid_o); end
    if (imem_req_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL redir_rsp_addr: got %h expected 00000100", imem_req_addr_o); end
    if (imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL redir_rsp_req_valid: got %b expected 1", imem_req_valid_o); end
    repeat (10) @(negedge clk);
    drain("redirect_rsp");
  endtask

  task automatic test_back_to_back();
    bit seen;
    mem_accept = 1'b1; mem_lat = 3; toggle_mode = 1'b0; instr_ready_i = 1'b1;
    do_reset();
    next_cycle();
    next_cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    next_cycle();
    redirect_pc_i = 32'h0000_0300;
    next_cycle();
    redirect_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid_o) begin
        seen = 1'b1;
        checks++;
        if (instr_o.pc !== 32'h0000_0300) begin
          errors++;
          $display("FAIL b2b_first_pc: got %h expected 00000300", instr_o.pc);
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_timeout: instr_valid=0 expected 1 within 20 cycles"); end
    repeat (8) @(negedge clk);
    drain("back_to_back");
  endtask

  task automatic test_toggle();
    bus32_t prev_addr;
    bit     prev_fire;
    mem_accept = 1'b1; mem_lat = 3; toggle_mode = 1'b1; instr_ready_i = 1'b1;
    do_reset();
    prev_fire = 1'b1;
    prev_addr = '0;
    for (int i = 0; i < 60; i++) begin
      instr_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!prev_fire) begin
        checks++;
        if (imem_req_addr_o !== prev_addr) begin
          errors++;
          $display("FAIL toggle_pc_hold: got %h expected %h", imem_req_addr_o, prev_addr);
        end
      end
      prev_fire = imem_req_valid_o && imem_req_ready_i;
      prev_addr = imem_req_addr_o;
      next_cycle();
    end
    toggle_mode = 1'b0;
    drain("toggle");
  endtask

  task automatic test_wrap_reset();
    bit found;
    mem_accept = 1'b1; mem_lat = 1; toggle_mode = 1'b0; instr_ready_i = 1'b1;
    do_reset();
    next_cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF4;
    next_cycle();
    redirect_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid_o && imem_req_ready_i && imem_req_addr_o == 32'hFFFF_FFFC) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL wrap_timeout: no request to FFFFFFFC expected within 20 cycles"); end
    @(negedge clk);
    checks++;
    if (imem_req_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", imem_req_addr_o); end
    repeat (3) next_cycle();
    rstn_i = 1'b0;
    next_cycle();
    @(negedge clk);
    checks += 2;
    if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_instr_valid: got %b expected 0", instr_valid_o); end
    if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_req_valid: got %b expected 0", imem_req_valid_o); end
    next_cycle();
    rstn_i = 1'b1;
    @(negedge clk);
    checks += 2;
    if (imem_req_addr_o !== RESET_PC) begin errors++; $display("FAIL midreset_addr: got %h expected %h", imem_req_addr_o, RESET_PC); end
    if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_post_valid: got %b expected 0", instr_valid_o); end
    repeat (8) @(negedge clk);
    drain("wrap_reset");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rsp();
    test_back_to_back();
    test_toggle();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage, directly upstream of decode.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned instruction words with their PC in a small FIFO and presents them to decode (immediate generation, register read) through a valid/ready handshake.
- Handles PC redirects from execute: flushes buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, instruction buffer entries and maximum in-flight requests (power of two, ≥2).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  synchronous, active-low reset.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_addr_o  out  32 (bus32_t)  request address, word-aligned.
- imem_req_ready_i  in  1  memory accepts request.
- imem_rsp_valid_i  in  1  response valid; responses return in request order.
- imem_rsp_data_i  in  32 (bus32_t)  instruction word.
- redirect_i  in  1  taken branch/jump from execute.
- redirect_pc_i  in  32 (bus32_t)  redirect target.
- instr_o  out  instr_data_t  instruction word and its PC, to decode.
- instr_valid_o  out  1  instr_o valid.
- instr_ready_i  in  1  decode accepts instr_o.

Behaviour:
- Clock and reset:
  - One clock: clk_i.
  - Reset is synchronous and active-low on rstn_i.
  - On reset: pc ← RESET_PC, FIFO empty, in-flight count 0, drop count 0, imem_req_valid_o=0, instr_valid_o=0, instr_o='0.
  - Reset mid-operation discards everything; responses arriving after reset to pre-reset requests are not expected (memory is reset in the same cycle).
- Request issue:
  - imem_req_valid_o=1 when (inflight + fifo_count) < DEPTH and redirect_i=0.
  - imem_req_addr_o=pc, with pc[1:0] forced 0.
  - Handshake when valid && ready: pc ← pc+4 (wraps 32'hFFFF_FFFC → 0), inflight++.
  - Each request pushes its PC into a PC queue (DEPTH entries) so the response can be paired with it.
- Response:
  - On imem_rsp_valid_i with drop_cnt=0: push {word, pc_queue head} into the FIFO, pop the PC queue, inflight--.
  - With drop_cnt>0: discard the word, pop the PC queue, inflight--, drop_cnt--.
  - Credit rule guarantees the FIFO is never full on an accepted response. A response while inflight=0 is an error: assertion, no state change.
- Output:
  - instr_valid_o = FIFO not empty; instr_o = FIFO head. Combinational from state only, with no path from ready_i or rsp_valid_i.
  - Pop when instr_valid_o && instr_ready_i.
  - Same-cycle push and pop at FIFO full or empty are legal; count is unchanged.
- Redirect (priority over everything in the same cycle):
  - pc ← {redirect_pc_i[31:2],2'b00}.
  - FIFO cleared; no pop is counted even if instr_ready_i=1.
  - drop_cnt ← inflight, minus 1 if a response arrives in that cycle (that response is itself discarded).
  - No request issued in the redirect cycle; the first request to the target is issued the next cycle.
  - Back-to-back redirects: the last one wins, and drop accounting accumulates correctly.
- Latency:
  - Minimum from request handshake to instr_valid_o is memory latency + 1 cycle.
  - Sustained throughput is 1 instruction/cycle with DEPTH=2 and 1-cycle memory.
- Stall:
  - instr_ready_i=0 holds instr_o stable.
  - Issue stops once inflight + fifo_count = DEPTH.

Test Plan:
- Reset, then ready memory with 1-cycle latency and decode always ready -> requests to 0x0, 0x4, 0x8…; instr_o.pc matches and instr_valid_o is continuous from the 3rd cycle.
- Decode holds instr_ready_i=0 for 5 cycles -> exactly DEPTH=2 requests issued; instr_o stays at the pc=0x0 word; on release both words are delivered in order with no loss.
- Redirect to 0x100 with 2 requests in flight -> both old responses discarded; first delivered instruction has pc=0x100; no old-PC words reach decode.
- Redirect with redirect_pc_i=0x103 in the same cycle as a response and instr_ready_i=1 -> response dropped, request address is 0x100 the next cycle, FIFO empty.
- imem_req_ready_i toggling 1/0 with 3-cycle response latency -> PC/word pairing correct and pc increments only on handshake.
- pc=0xFFFF_FFFC -> next request address 0x0000_0000; rstn_i low mid-stream -> next request at RESET_PC with instr_valid_o=0.
